// File: rtl/jk_seq_ctrl_pkg.sv
// Shared types for the JK sequencer: FSM states, operation modes and a mode helper.
package jk_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_LD  = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  function automatic logic is_count(input mode_e m);
    return (m == MODE_UP) || (m == MODE_DN);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single posedge JK flip-flop with active-high asynchronous reset.
module jk_cell (
  input  logic clk,
  input  logic reset_async,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencer driving a bank of JK flip-flops: counts up/down for a number of steps,
// or loads/clears the bank in one step.
module jk_seq_ctrl
  import jk_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = 8
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [STEPW-1:0] steps,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [WIDTH-1:0]   load_q, load_d;
  logic [STEPW-1:0]   rem_q, rem_d;
  logic               wrap_q, wrap_d;
  logic [WIDTH-1:0]   up_en, dn_en;

  // Toggle enables: bit i flips when all lower bits are ones (up) or zeros (down).
  assign up_en[0] = 1'b1;
  assign dn_en[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_en
    assign up_en[i] = &q[i-1:0];
    assign dn_en[i] = ~|q[i-1:0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    jk_cell u_cell (
      .clk         (clk),
      .reset_async (reset_async),
      .j           (j_vec[i]),
      .k           (k_vec[i]),
      .q           (q[i])
    );
  end

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      load_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    load_d  = load_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode_e'(mode);
          load_d = load_val;
          if (is_count(mode_e'(mode))) begin
            rem_d   = steps;
            state_d = (steps == '0) ? DONE : RUN;
          end else begin
            // Load and clear always take exactly one step.
            rem_d   = STEPW'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d  = rem_q - STEPW'(1);
        wrap_d = ((mode_q == MODE_UP) && (&q)) || ((mode_q == MODE_DN) && (~|q));
        if (rem_q == STEPW'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    wrap  = wrap_q;
    j_vec = '0;
    k_vec = '0;
    if (state_q == RUN) begin
      unique case (mode_q)
        MODE_UP: begin
          j_vec = up_en;
          k_vec = up_en;
        end
        MODE_DN: begin
          j_vec = dn_en;
          k_vec = dn_en;
        end
        MODE_LD: begin
          j_vec = load_q;
          k_vec = ~load_q;
        end
        MODE_CLR: begin
          j_vec = '0;
          k_vec = '1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4, meaning the number of JK flip-flop stages controlled.
REQ-002 The block SHALL expose parameter STEPW, default 8, meaning the width of the step-count input.
REQ-003 Port clk SHALL be an input of 1 bit and act as the single clock; all state SHALL update on its posedge.
REQ-004 Port reset_async SHALL be an input of 1 bit; reset is asynchronous and active-high.
REQ-005 Port start SHALL be an input of 1 bit and request an operation.
REQ-006 Port mode SHALL be an input of 2 bits: 00 count up, 01 count down, 10 load, 11 clear.
REQ-007 Port load_val SHALL be an input of WIDTH bits and give the load data.
REQ-008 Port steps SHALL be an input of STEPW bits and give the number of count steps.
REQ-009 Port q SHALL be an output of WIDTH bits and carry the flip-flop bank state.
REQ-010 Ports j_vec and k_vec SHALL be outputs of WIDTH bits each and carry the excitation currently applied to the bank.
REQ-011 Port busy SHALL be an output of 1 bit, high in RUN.
REQ-012 Port done SHALL be an output of 1 bit, a one-cycle pulse in DONE.
REQ-013 Port wrap SHALL be an output of 1 bit, a registered one-cycle pulse on counter wrap.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL latch mode, load_val and steps at the edge and move to RUN; if steps=0 in a count mode, it SHALL move directly to DONE with q unchanged.
REQ-016 start SHALL be ignored in RUN and DONE, with no latching and no queuing.
REQ-017 In RUN, each edge SHALL apply exactly one step to the bank, and the remaining count SHALL decrement.
REQ-018 The FSM SHALL go RUN->DONE on the edge that applies the last step: steps edges for count modes, and exactly 1 edge for load or clear, regardless of steps.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-020 Count-up excitation SHALL be j_vec[i]=k_vec[i]=AND(q[i-1:0]), with bit 0 always toggling.
REQ-021 Count-down excitation SHALL be j_vec[i]=k_vec[i]=AND(~q[i-1:0]).
REQ-022 Load excitation SHALL be j_vec=load_val and k_vec=~load_val (latched copy).
REQ-023 Clear excitation SHALL be j_vec=0 and k_vec=all-ones.
REQ-024 Outside RUN, j_vec=k_vec=0 (hold), and q SHALL be unchanged.
REQ-025 Each bank bit SHALL follow JK semantics on the edge: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-026 The counter SHALL wrap modulo 2^WIDTH: up from all-ones to 0, and down from 0 to all-ones.
REQ-027 wrap SHALL be high during the cycle following any step edge that produced a wrap, and low otherwise; load and clear SHALL never raise wrap.
REQ-028 busy and done SHALL never be high simultaneously.

Reset
REQ-029 reset_async=1 SHALL immediately force state IDLE, q=0, remaining=0, busy=0, done=0 and wrap=0, with j_vec=k_vec=0.
REQ-030 Reset during RUN or DONE SHALL abort the operation with no done pulse; normal operation SHALL resume on the first edge after deassertion.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the mode encodings (MODE_UP, MODE_DN, MODE_LD, MODE_CLR).
REQ-032 The bank SHALL be WIDTH instances of one sub-module, jk_cell, a posedge JK flip-flop with active-high async reset; the excitation logic and FSM SHALL stay in jk_seq_ctrl.

Verification
REQ-033 Reset then start, mode=00, steps=3 -> busy for 3 cycles, q=1,2,3, done pulse in the next cycle, wrap=0.
REQ-034 Load 4'hE, then up with steps=3 -> q=F,0,1; wrap high for the cycle after the F->0 edge; done once.
REQ-035 From q=0, down with steps=2 -> q=F,E; wrap pulses once; then clear -> q=0 after 1 RUN cycle, done pulse.
REQ-036 Up with steps=0 -> no RUN cycle, done the next cycle, q unchanged; load with steps=0 and load_val=5 -> q=5 after one RUN cycle.
REQ-037 start held high during RUN and DONE -> ignored; a new operation begins only from IDLE, and done pulses once per accepted start.
REQ-038 reset_async asserted mid-RUN (up, steps=10, after 4 steps) -> q=0, busy=0 immediately, no done pulse; a subsequent start runs normally.
